// File: rtl/hazard_unit.sv
// hazard_unit: load-use/flag-use stall, branch flush and EX forward-select generation
// Ports:
//   clk, reset (async, active-low)
//   id_rn/id_rm/id_rd, id_use_rn/id_use_rm, id_reg_write, id_mem_read,
//   id_set_flags, id_cbranch : ID-stage decode fields
//   ex_branch_taken          : branch resolved taken in EX
//   stall/bubble/flush       : front-end hold, ID/EX NOP insert, IF/ID squash
//   fwd_sel_a/fwd_sel_b      : registered EX operand selects (00 RF, 01 MEM ALU, 10 WB)
//   flag_fwd                 : B.cond in ID uses the EX ALU flags
//   stall_cnt                : saturating stalled-cycle counter
// Build option: HAZARD_FLAG_STALL_EN stalls B.cond behind a flag-setter instead of forwarding flags.
module hazard_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rn,
  input  logic [4:0]  id_rm,
  input  logic        id_use_rn,
  input  logic        id_use_rm,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_set_flags,
  input  logic        id_cbranch,
  input  logic        ex_branch_taken,
  output logic        stall,
  output logic        bubble,
  output logic        flush,
  output logic [1:0]  fwd_sel_a,
  output logic [1:0]  fwd_sel_b,
  output logic        flag_fwd,
  output logic [15:0] stall_cnt
);
  typedef enum logic [1:0] {IDLE = 2'b00, FWD_EX = 2'b01, FWD_WB = 2'b10} fwd_e;
  logic [4:0]  r_ex_rd, r_mem_rd;
  logic        r_ex_wr, r_ex_ld, r_ex_fl, r_mem_wr;
  fwd_e        r_sel_a, r_sel_b;
  logic [15:0] r_stall_cnt;
  logic        w_a_ex, w_b_ex, w_a_mem, w_b_mem, w_load_use, w_flag_hz, w_hz;
  fwd_e        w_sel_a, w_sel_b;
  // XZR (31) is never a real dependency
  assign w_a_ex  = id_use_rn && id_rn != 5'd31 && r_ex_wr  && id_rn == r_ex_rd;
  assign w_b_ex  = id_use_rm && id_rm != 5'd31 && r_ex_wr  && id_rm == r_ex_rd;
  assign w_a_mem = id_use_rn && id_rn != 5'd31 && r_mem_wr && id_rn == r_mem_rd;
  assign w_b_mem = id_use_rm && id_rm != 5'd31 && r_mem_wr && id_rm == r_mem_rd;
  assign w_load_use = (w_a_ex || w_b_ex) && r_ex_ld;
  // a load in EX cannot forward yet; that case is bubbled, so its select is never registered
  assign w_sel_a = (w_a_ex && !r_ex_ld) ? FWD_EX : w_a_mem ? FWD_WB : IDLE;
  assign w_sel_b = (w_b_ex && !r_ex_ld) ? FWD_EX : w_b_mem ? FWD_WB : IDLE;
`ifdef HAZARD_FLAG_STALL_EN
  assign w_flag_hz = id_cbranch && r_ex_fl;
  assign flag_fwd  = 1'b0;
`else
  assign w_flag_hz = 1'b0;
  assign flag_fwd  = id_cbranch && r_ex_fl;
`endif
  assign w_hz = w_load_use || w_flag_hz;
  // a taken branch makes the ID instruction wrong-path, so never hold it
  assign stall     = w_hz && !ex_branch_taken;
  assign bubble    = w_hz || ex_branch_taken;
  assign flush     = ex_branch_taken;
  assign fwd_sel_a = r_sel_a;
  assign fwd_sel_b = r_sel_b;
  assign stall_cnt = r_stall_cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex_rd     <= '0;
      r_ex_wr     <= 1'b0;
      r_ex_ld     <= 1'b0;
      r_ex_fl     <= 1'b0;
      r_mem_rd    <= '0;
      r_mem_wr    <= 1'b0;
      r_sel_a     <= IDLE;
      r_sel_b     <= IDLE;
      r_stall_cnt <= '0;
    end else begin
      r_mem_rd    <= r_ex_rd;
      r_mem_wr    <= r_ex_wr;
      r_ex_rd     <= bubble ? 5'd0 : id_rd;
      r_ex_wr     <= !bubble && id_reg_write;
      r_ex_ld     <= !bubble && id_mem_read;
      r_ex_fl     <= !bubble && id_set_flags;
      r_sel_a     <= bubble ? IDLE : w_sel_a;
      r_sel_b     <= bubble ? IDLE : w_sel_b;
      r_stall_cnt <= (stall && r_stall_cnt != 16'hFFFF) ? r_stall_cnt + 16'd1 : r_stall_cnt;
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: randomized and directed checks of hazard_unit against an in-flight instruction model
module tb_hazard_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  id_rn = '0, id_rm = '0, id_rd = '0;
  logic        id_use_rn = 0, id_use_rm = 0, id_reg_write = 0, id_mem_read = 0;
  logic        id_set_flags = 0, id_cbranch = 0, ex_branch_taken = 0;
  logic        stall, bubble, flush, flag_fwd;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic [15:0] stall_cnt;

  hazard_unit dut (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_set_flags(id_set_flags), .id_cbranch(id_cbranch), .ex_branch_taken(ex_branch_taken),
    .stall(stall), .bubble(bubble), .flush(flush),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .flag_fwd(flag_fwd), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {logic [4:0] rd; logic wr; logic ld; logic fl;} ins_t;
  ins_t pipe[$];
  logic [1:0] m_sel_a, m_sel_b;
  int n_vec, n_err, m_cnt;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit dep(input logic u, input logic [4:0] a, input ins_t s);
    return u && a != 5'd31 && s.wr && a == s.rd;
  endfunction

  function automatic logic [1:0] src(input logic u, input logic [4:0] a);
    if (dep(u, a, pipe[0]) && !pipe[0].ld) return 2'b01;
    if (dep(u, a, pipe[1])) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    ins_t nop = '{rd: 5'd0, wr: 1'b0, ld: 1'b0, fl: 1'b0};
    pipe = {};
    pipe.push_back(nop);
    pipe.push_back(nop);
    m_sel_a = 2'b00;
    m_sel_b = 2'b00;
    m_cnt = 0;
  endtask

  task automatic set_id(input logic [4:0] rn, input logic urn, input logic [4:0] rm, input logic urm,
                        input logic [4:0] rd, input logic wr, input logic ld, input logic fl,
                        input logic cb, input logic tk);
    id_rn = rn; id_use_rn = urn; id_rm = rm; id_use_rm = urm;
    id_rd = rd; id_reg_write = wr; id_mem_read = ld; id_set_flags = fl;
    id_cbranch = cb; ex_branch_taken = tk;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // check one cycle at the falling edge, then advance the model across the rising edge
  task automatic step();
    bit lu, fh, hz, e_stall, e_bub;
    logic [1:0] na, nb;
    ins_t nxt;
    @(negedge clk);
    lu = (dep(id_use_rn, id_rn, pipe[0]) || dep(id_use_rm, id_rm, pipe[0])) && pipe[0].ld;
`ifdef HAZARD_FLAG_STALL_EN
    fh = id_cbranch && pipe[0].fl;
    check("flag_fwd", {15'd0, flag_fwd}, 16'd0);
`else
    fh = 1'b0;
    check("flag_fwd", {15'd0, flag_fwd}, {15'd0, id_cbranch && pipe[0].fl});
`endif
    hz = lu || fh;
    e_stall = hz && !ex_branch_taken;
    e_bub = hz || ex_branch_taken;
    check("stall", {15'd0, stall}, {15'd0, e_stall});
    check("bubble", {15'd0, bubble}, {15'd0, e_bub});
    check("flush", {15'd0, flush}, {15'd0, ex_branch_taken});
    check("fwd_sel_a", {14'd0, fwd_sel_a}, {14'd0, m_sel_a});
    check("fwd_sel_b", {14'd0, fwd_sel_b}, {14'd0, m_sel_b});
    check("stall_cnt", stall_cnt, m_cnt[15:0]);
    na = e_bub ? 2'b00 : src(id_use_rn, id_rn);
    nb = e_bub ? 2'b00 : src(id_use_rm, id_rm);
    nxt = e_bub ? '{rd: 5'd0, wr: 1'b0, ld: 1'b0, fl: 1'b0}
                : '{rd: id_rd, wr: id_reg_write, ld: id_mem_read, fl: id_set_flags};
    @(posedge clk);
    pipe.pop_back();
    pipe.push_front(nxt);
    m_sel_a = na;
    m_sel_b = nb;
    if (e_stall && m_cnt < 65535) m_cnt++;
    #1;
  endtask

  function automatic logic [4:0] rreg();
    logic [4:0] r;
    r = 5'($urandom_range(0, 4));
    return r == 5'd4 ? 5'd31 : r;
  endfunction

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", {15'd0, stall}, 16'd0);
    check("rst_cnt", stall_cnt, 16'd0);
    reset = 1'b1;
    nop();
    repeat (10) step();

    // ADD X3 ; SUB X5,X3,X2 -> EX forward on A
    set_id(0, 0, 0, 0, 3, 1, 0, 0, 0, 0); step();
    set_id(3, 1, 2, 1, 5, 1, 0, 0, 0, 0); step();
    check("sub_fwd_a_ex", {14'd0, fwd_sel_a}, 16'd1);
    check("sub_fwd_b_rf", {14'd0, fwd_sel_b}, 16'd0);
    // ADD X3 ; NOP ; SUB -> WB forward
    set_id(0, 0, 0, 0, 3, 1, 0, 0, 0, 0); step();
    nop(); step();
    set_id(3, 1, 2, 1, 5, 1, 0, 0, 0, 0); step();
    check("sub_fwd_a_wb", {14'd0, fwd_sel_a}, 16'd2);

    // LDUR X4 ; ADD X6,X4,X4 -> one stall then WB forward on both
    set_id(0, 0, 0, 0, 4, 1, 1, 0, 0, 0); step();
    set_id(4, 1, 4, 1, 6, 1, 0, 0, 0, 0);
    #1 check("lu_stall", {15'd0, stall}, 16'd1);
    step();
    check("lu_one_cycle", {15'd0, stall}, 16'd0);
    step();
    check("lu_fwd_a", {14'd0, fwd_sel_a}, 16'd2);
    check("lu_fwd_b", {14'd0, fwd_sel_b}, 16'd2);
    check("lu_cnt", stall_cnt, 16'd1);

    // XZR never forwards; EX beats MEM
    set_id(0, 0, 0, 0, 31, 1, 0, 0, 0, 0); step();
    set_id(31, 1, 31, 1, 8, 1, 0, 0, 0, 0); step();
    check("xzr_fwd_a", {14'd0, fwd_sel_a}, 16'd0);
    set_id(0, 0, 0, 0, 7, 1, 0, 0, 0, 0); step(); step();
    set_id(7, 1, 0, 0, 9, 1, 0, 0, 0, 0); step();
    check("ex_over_mem", {14'd0, fwd_sel_a}, 16'd1);

    // taken branch overrides a load-use stall
    set_id(0, 0, 0, 0, 4, 1, 1, 0, 0, 0); step();
    set_id(4, 1, 0, 0, 6, 1, 0, 0, 0, 1);
    #1 check("tk_flush", {15'd0, flush}, 16'd1);
    check("tk_stall", {15'd0, stall}, 16'd0);
    step();
    check("tk_cnt", stall_cnt, 16'd1);

    // SUBS ; B.cond
    nop(); step();
    set_id(0, 0, 0, 0, 1, 1, 0, 1, 0, 0); step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
`ifdef HAZARD_FLAG_STALL_EN
    #1 check("fl_stall", {15'd0, stall}, 16'd1);
    check("fl_fwd", {15'd0, flag_fwd}, 16'd0);
`else
    #1 check("fl_stall", {15'd0, stall}, 16'd0);
    check("fl_fwd", {15'd0, flag_fwd}, 16'd1);
`endif
    step(); nop(); step();

    // asynchronous reset in the middle of a stall
    set_id(0, 0, 0, 0, 4, 1, 1, 0, 0, 0); step();
    set_id(4, 1, 4, 1, 6, 1, 0, 0, 0, 0);
    #1 check("pre_rst_stall", {15'd0, stall}, 16'd1);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_stall", {15'd0, stall}, 16'd0);
    check("mid_rst_bubble", {15'd0, bubble}, 16'd0);
    check("mid_rst_fwd_a", {14'd0, fwd_sel_a}, 16'd0);
    check("mid_rst_cnt", stall_cnt, 16'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    nop(); step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      set_id(rreg(), 1'($urandom), rreg(), 1'($urandom), rreg(), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), $urandom_range(0, 9) == 0);
      step();
    end

    // saturation: preload near the top, then keep stalling
    force dut.r_stall_cnt = 16'hFFF0;
    #1 release dut.r_stall_cnt;
    m_cnt = 16'hFFF0;
    nop(); step();
    for (int i = 0; i < 20; i++) begin
      set_id(0, 0, 0, 0, 1, 1, 1, 0, 0, 0); step();
      set_id(1, 1, 0, 0, 2, 1, 0, 0, 0, 0); step();
    end
    nop(); step();
    check("cnt_sat", stall_cnt, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
